// File: rtl/i2c_multi_addr_checker.sv
// I2C slave address-phase checker: glitch-filtered START/STOP detection plus
// multi-slot 7/10-bit address resolution (including 10-bit read and general call).
module i2c_multi_addr_checker #(
  parameter int NUM_ADDR   = 2,
  parameter int FILTER_LEN = 2,
  localparam int IW        = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  SDA_sync,
  input  logic                  SCL_sync,
  input  logic [7:0]            rx_data,
  input  logic                  byte_valid,
  input  logic [10*NUM_ADDR-1:0] bus_address,
  input  logic [NUM_ADDR-1:0]   address_mode,
  input  logic [NUM_ADDR-1:0]   addr_enable,
  input  logic                  gc_enable,
  output logic                  start,
  output logic                  stop,
  output logic                  rep_start,
  output logic                  bus_busy,
  output logic                  rw_mode,
  output logic                  address_match,
  output logic [IW-1:0]         match_index,
  output logic                  general_call,
  output logic                  addr_done
);

  typedef enum logic [2:0] {IDLE, ADDR1, ADDR2, MATCHED, IGNORE} state_t;

  state_t state, state_n;

  // Glitch filter: the window holds the FILTER_LEN most recent samples, newest in bit 0.
  logic [FILTER_LEN-1:0] sda_hist, scl_hist;
  logic [FILTER_LEN-1:0] sda_win, scl_win;
  logic                  sda_f, scl_f, sda_f_q, scl_f_q;
  logic                  start_cond, stop_cond;

  assign sda_win = (sda_hist << 1) | FILTER_LEN'(SDA_sync);
  assign scl_win = (scl_hist << 1) | FILTER_LEN'(SCL_sync);

  assign start_cond = scl_f & scl_f_q & sda_f_q & ~sda_f;
  assign stop_cond  = scl_f & scl_f_q & ~sda_f_q & sda_f;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sda_hist <= '1;
      scl_hist <= '1;
      sda_f    <= 1'b1;
      scl_f    <= 1'b1;
      sda_f_q  <= 1'b1;
      scl_f_q  <= 1'b1;
    end else begin
      sda_hist <= sda_win;
      scl_hist <= scl_win;
      if (&sda_win)       sda_f <= 1'b1;
      else if (~|sda_win) sda_f <= 1'b0;
      if (&scl_win)       scl_f <= 1'b1;
      else if (~|scl_win) scl_f <= 1'b0;
      sda_f_q <= sda_f;
      scl_f_q <= scl_f;
    end
  end

  // Slot comparison; iterating downward lets the lowest matching index win.
  logic                hit7, hit2;
  logic [IW-1:0]       idx7, idx2;
  logic [NUM_ADDR-1:0] mask10;
  logic [NUM_ADDR-1:0] cand_mask, cand_n;
  logic                armed_valid, armv_n;
  logic [IW-1:0]       armed_idx, armi_n;
  logic [1:0]          armed_hi;

  always_comb begin
    hit7   = 1'b0;
    idx7   = '0;
    hit2   = 1'b0;
    idx2   = '0;
    mask10 = '0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      if (addr_enable[i] && !address_mode[i] && bus_address[10*i +: 7] == rx_data[7:1]) begin
        hit7 = 1'b1;
        idx7 = IW'(i);
      end
      if (addr_enable[i] && address_mode[i] && bus_address[10*i+8 +: 2] == rx_data[2:1])
        mask10[i] = 1'b1;
      if (cand_mask[i] && bus_address[10*i +: 8] == rx_data) begin
        hit2 = 1'b1;
        idx2 = IW'(i);
      end
    end
  end

  assign armed_hi = bus_address[10*int'(armed_idx)+8 +: 2];

  // byte_valid is a one-cycle strobe with no back-pressure: rx_data is consumed
  // only on that cycle and only in ADDR1/ADDR2, and a coincident START/STOP drops it.
  logic          busy_n, rw_n, match_n, gc_n, done_n;
  logic [IW-1:0] idx_n;

  always_comb begin
    state_n = state;
    busy_n  = bus_busy;
    rw_n    = rw_mode;
    match_n = address_match;
    idx_n   = match_index;
    gc_n    = general_call;
    done_n  = 1'b0;
    armv_n  = armed_valid;
    armi_n  = armed_idx;
    cand_n  = cand_mask;
    if (stop_cond) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      match_n = 1'b0;
      gc_n    = 1'b0;
      idx_n   = '0;
      armv_n  = 1'b0;
      armi_n  = '0;
    end else if (start_cond) begin
      state_n = ADDR1;
      busy_n  = 1'b1;
      match_n = 1'b0;
      gc_n    = 1'b0;
    end else if (byte_valid) begin
      case (state)
        ADDR1: begin
          rw_n    = rx_data[0];
          done_n  = 1'b1;
          state_n = IGNORE;
          match_n = 1'b0;
          gc_n    = 1'b0;
          idx_n   = '0;
          if (rx_data == 8'h00 && gc_enable) begin
            state_n = MATCHED;
            match_n = 1'b1;
            gc_n    = 1'b1;
          end else if (rx_data[7:3] == 5'b11110) begin
            if (!rx_data[0]) begin
              if (|mask10) begin
                state_n = ADDR2;
                cand_n  = mask10;
                done_n  = 1'b0;
                match_n = address_match;
                idx_n   = match_index;
              end
            end else if (armed_valid && armed_hi == rx_data[2:1]) begin
              state_n = MATCHED;
              match_n = 1'b1;
              idx_n   = armed_idx;
            end
          end else if (hit7) begin
            state_n = MATCHED;
            match_n = 1'b1;
            idx_n   = idx7;
          end
        end
        ADDR2: begin
          done_n = 1'b1;
          gc_n   = 1'b0;
          if (hit2) begin
            state_n = MATCHED;
            match_n = 1'b1;
            idx_n   = idx2;
            armv_n  = 1'b1;
            armi_n  = idx2;
          end else begin
            state_n = IGNORE;
            match_n = 1'b0;
            idx_n   = '0;
            armv_n  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      bus_busy      <= 1'b0;
      rw_mode       <= 1'b0;
      address_match <= 1'b0;
      match_index   <= '0;
      general_call  <= 1'b0;
      addr_done     <= 1'b0;
      armed_valid   <= 1'b0;
      armed_idx     <= '0;
      cand_mask     <= '0;
      start         <= 1'b0;
      stop          <= 1'b0;
      rep_start     <= 1'b0;
    end else begin
      state         <= state_n;
      bus_busy      <= busy_n;
      rw_mode       <= rw_n;
      address_match <= match_n;
      match_index   <= idx_n;
      general_call  <= gc_n;
      addr_done     <= done_n;
      armed_valid   <= armv_n;
      armed_idx     <= armi_n;
      cand_mask     <= cand_n;
      start         <= start_cond & ~bus_busy;
      rep_start     <= start_cond & bus_busy;
      stop          <= stop_cond;
    end
  end

endmodule
